// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_BUBBLE = 2'd1,
    MEM_WAIT  = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A load in EX whose destination is read by the instruction sitting in ID.
  function automatic logic load_use(input logic       ex_mem_read,
                                    input logic       ex_write,
                                    input logic [4:0] ex_rd,
                                    input logic [4:0] id_rs,
                                    input logic [4:0] id_rt,
                                    input logic       id_uses_rt);
    return ex_mem_read && ex_write && (ex_rd != REG_ZERO) &&
           ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the hazard controller (master) and the pipeline/memory side (slave).
interface hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        ex_mem_read;
  logic        ex_write;
  logic [4:0]  ex_rdNum;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        pipe_hold;
  logic        mem_timeout;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_write, ex_rdNum,
           branch_taken, mem_req, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold,
           mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_write, ex_rdNum,
           branch_taken, mem_req, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold,
           mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_perf_cnt.sv
// Stall and flush performance counters, wrapping modulo 2**32.
module hazard_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_stall,
  input  logic        i_flush,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
);

  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (i_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (i_flush) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / branch / memory-wait hazard controller for the 5-stage pipeline.
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.master bus
);

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [TO_W-1:0] r_cnt;
  logic [TO_W-1:0] w_cnt_nxt;
  logic            r_if_id_flush;
  logic            r_id_ex_flush;
  logic            r_mem_timeout;
  logic            w_if_id_flush_nxt;
  logic            w_id_ex_flush_nxt;
  logic            w_mem_timeout_nxt;
  logic            w_lu;
  logic            w_mw;
  logic            w_pipe_hold;
  logic            w_pc_write;
  logic            w_flush_ok;

  assign w_lu = load_use(bus.ex_mem_read, bus.ex_write, bus.ex_rdNum,
                         bus.id_rs, bus.id_rt, bus.id_uses_rt);
  assign w_mw = bus.mem_req && !bus.mem_ready;
  assign w_pipe_hold = w_mw || ((r_state == MEM_WAIT) && !bus.mem_ready);
  assign w_pc_write  = !(w_pipe_hold || w_lu);
  // Flush pulses must never be back to back.
  assign w_flush_ok  = !(r_if_id_flush || r_id_ex_flush);

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_if_id_flush_nxt = 1'b0;
    w_id_ex_flush_nxt = 1'b0;
    unique case (r_state)
      RUN: begin
        if (w_mw) begin
          w_state_nxt = MEM_WAIT;
          w_cnt_nxt   = TO_W'(1);
        end else if (w_lu && w_flush_ok) begin
          w_state_nxt       = LU_BUBBLE;
          w_id_ex_flush_nxt = 1'b1;
        end else if (bus.branch_taken && w_flush_ok) begin
          w_if_id_flush_nxt = 1'b1;
        end
      end
      LU_BUBBLE: begin
        if (w_mw) begin
          w_state_nxt = MEM_WAIT;
          w_cnt_nxt   = TO_W'(1);
        end else begin
          w_state_nxt = RUN;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ready) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end else if (r_cnt < TO_MAX) begin
          w_cnt_nxt = r_cnt + TO_W'(1);
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end
    endcase
    w_mem_timeout_nxt = r_mem_timeout ||
                        ((w_state_nxt == MEM_WAIT) && (w_cnt_nxt == TO_MAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= RUN;
      r_cnt         <= '0;
      r_if_id_flush <= 1'b0;
      r_id_ex_flush <= 1'b0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_if_id_flush <= w_if_id_flush_nxt;
      r_id_ex_flush <= w_id_ex_flush_nxt;
      r_mem_timeout <= w_mem_timeout_nxt;
    end
  end

  assign bus.pc_write    = w_pc_write;
  assign bus.if_id_write = w_pc_write;
  assign bus.pipe_hold   = w_pipe_hold;
  assign bus.if_id_flush = r_if_id_flush;
  assign bus.id_ex_flush = r_id_ex_flush;
  assign bus.mem_timeout = r_mem_timeout;

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt u_perf_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_stall     (!w_pc_write),
    .i_flush     (r_if_id_flush || r_id_ex_flush),
    .o_stall_cnt (bus.stall_cnt),
    .o_flush_cnt (bus.flush_cnt)
  );
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (MEM_TIMEOUT=4); counters checked when HAZARD_PERF_CNT_EN is set.
module tb_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       u;
    logic       mr;
    logic       wr;
    logic [4:0] rd;
    logic       br;
    logic       rq;
    logic       ry;
  } stim_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;
  logic [5:0] sb[$];

  hazard_ctrl_if bus ();

  hazard_ctrl #(
    .MEM_TIMEOUT (4),
    .TO_W        (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic u,
                               input logic mr, input logic wr, input logic [4:0] rd,
                               input logic br, input logic rq, input logic ry);
    stim_t s;
    s = '{rs: rs, rt: rt, u: u, mr: mr, wr: wr, rd: rd, br: br, rq: rq, ry: ry};
    return s;
  endfunction

  // {pc_write, if_id_write, pipe_hold, if_id_flush, id_ex_flush, mem_timeout}
  function automatic logic [5:0] obs();
    return {bus.pc_write, bus.if_id_write, bus.pipe_hold,
            bus.if_id_flush, bus.id_ex_flush, bus.mem_timeout};
  endfunction

  task automatic drive(input stim_t s);
    bus.id_rs        = s.rs;
    bus.id_rt        = s.rt;
    bus.id_uses_rt   = s.u;
    bus.ex_mem_read  = s.mr;
    bus.ex_write     = s.wr;
    bus.ex_rdNum     = s.rd;
    bus.branch_taken = s.br;
    bus.mem_req      = s.rq;
    bus.mem_ready    = s.ry;
  endtask

  // Drive a vector just after the falling edge and queue its expected outputs.
  task automatic apply(input stim_t s, input logic [5:0] e);
    @(negedge clk);
    drive(s);
    sb.push_back(e);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    #2;
    got = obs();
    n_vec++;
    if (got !== 6'b110000) begin
      n_bad++;
      $display("FAIL reset_outputs got=%b exp=%b", got, 6'b110000);
    end
`ifdef HAZARD_PERF_CNT_EN
    n_vec++;
    if ({bus.stall_cnt, bus.flush_cnt} !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_counters got=%0d/%0d exp=0/0", bus.stall_cnt, bus.flush_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    stim_t st[3];
    logic [5:0] ex[3];
    logic [5:0] got, e;
    do_reset();
    st[0] = mk(5'd8, 5'd3, 0, 1, 1, 5'd8, 0, 0, 0); ex[0] = 6'b000000;
    st[1] = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0); ex[1] = 6'b110010;
    st[2] = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0); ex[2] = 6'b110000;
    for (int i = 0; i < 3; i++) begin
      apply(st[i], ex[i]);
      e = sb.pop_front();
      got = obs();
      n_vec++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL load_use[%0d] got=%b exp=%b", i, got, e);
      end
    end
`ifdef HAZARD_PERF_CNT_EN
    n_vec++;
    if ({bus.stall_cnt, bus.flush_cnt} !== {32'd1, 32'd1}) begin
      n_bad++;
      $display("FAIL load_use_cnt got=%0d/%0d exp=1/1", bus.stall_cnt, bus.flush_cnt);
    end
`endif
  endtask

  task automatic test_rt_gate();
    stim_t st[6];
    logic [5:0] ex[6];
    logic [5:0] got, e;
    do_reset();
    st[0] = mk(5'd1, 5'd9, 0, 1, 1, 5'd9, 0, 0, 0); ex[0] = 6'b110000;
    st[1] = mk(5'd1, 5'd9, 1, 1, 1, 5'd9, 0, 0, 0); ex[1] = 6'b000000;
    st[2] = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0); ex[2] = 6'b110010;
    st[3] = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0); ex[3] = 6'b110000;
    st[4] = mk(5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 0); ex[4] = 6'b110000;
    st[5] = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0); ex[5] = 6'b110000;
    for (int i = 0; i < 6; i++) begin
      apply(st[i], ex[i]);
      e = sb.pop_front();
      got = obs();
      n_vec++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL rt_gate[%0d] got=%b exp=%b", i, got, e);
      end
    end
  endtask

  task automatic test_branch();
    stim_t st[3];
    logic [5:0] ex[3];
    logic [5:0] got, e;
    do_reset();
    st[0] = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0); ex[0] = 6'b110000;
    st[1] = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0); ex[1] = 6'b110100;
    st[2] = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0); ex[2] = 6'b110000;
    for (int i = 0; i < 3; i++) begin
      apply(st[i], ex[i]);
      e = sb.pop_front();
      got = obs();
      n_vec++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL branch[%0d] got=%b exp=%b", i, got, e);
      end
    end
`ifdef HAZARD_PERF_CNT_EN
    n_vec++;
    if ({bus.stall_cnt, bus.flush_cnt} !== {32'd0, 32'd1}) begin
      n_bad++;
      $display("FAIL branch_cnt got=%0d/%0d exp=0/1", bus.stall_cnt, bus.flush_cnt);
    end
`endif
  endtask

  // Repeated branch inside a flush cycle is ignored; load-use beats branch.
  task automatic test_back_to_back();
    stim_t st[6];
    logic [5:0] ex[6];
    logic [5:0] got, e;
    do_reset();
    st[0] = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0); ex[0] = 6'b110000;
    st[1] = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0); ex[1] = 6'b110100;
    st[2] = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0); ex[2] = 6'b110000;
    st[3] = mk(5'd4, 5'd0, 0, 1, 1, 5'd4, 1, 0, 0); ex[3] = 6'b000000;
    st[4] = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0); ex[4] = 6'b110010;
    st[5] = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0); ex[5] = 6'b110000;
    for (int i = 0; i < 6; i++) begin
      apply(st[i], ex[i]);
      e = sb.pop_front();
      got = obs();
      n_vec++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL back_to_back[%0d] got=%b exp=%b", i, got, e);
      end
    end
  endtask

  task automatic test_mem_wait();
    stim_t st[5];
    logic [5:0] ex[5];
    logic [5:0] got, e;
    do_reset();
    st[0] = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0); ex[0] = 6'b001000;
    st[1] = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0); ex[1] = 6'b001000;
    st[2] = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0); ex[2] = 6'b001000;
    st[3] = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1); ex[3] = 6'b110000;
    st[4] = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0); ex[4] = 6'b110000;
    for (int i = 0; i < 5; i++) begin
      apply(st[i], ex[i]);
      e = sb.pop_front();
      got = obs();
      n_vec++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL mem_wait[%0d] got=%b exp=%b", i, got, e);
      end
    end
`ifdef HAZARD_PERF_CNT_EN
    n_vec++;
    if ({bus.stall_cnt, bus.flush_cnt} !== {32'd3, 32'd0}) begin
      n_bad++;
      $display("FAIL mem_wait_cnt got=%0d/%0d exp=3/0", bus.stall_cnt, bus.flush_cnt);
    end
`endif
  endtask

  task automatic test_timeout();
    stim_t st[8];
    logic [5:0] ex[8];
    logic [5:0] got, e;
    do_reset();
    for (int i = 0; i < 6; i++) st[i] = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
    st[6] = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1);
    st[7] = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0);
    ex[0] = 6'b001000; ex[1] = 6'b001000; ex[2] = 6'b001000; ex[3] = 6'b001000;
    ex[4] = 6'b001001; ex[5] = 6'b001001; ex[6] = 6'b110001; ex[7] = 6'b110001;
    for (int i = 0; i < 8; i++) begin
      apply(st[i], ex[i]);
      e = sb.pop_front();
      got = obs();
      n_vec++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL timeout[%0d] got=%b exp=%b", i, got, e);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = obs();
    n_vec++;
    if (got !== 6'b110000) begin
      n_bad++;
      $display("FAIL timeout_clear got=%b exp=%b", got, 6'b110000);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_priority_reset();
    stim_t st[6];
    logic [5:0] ex[6];
    logic [5:0] got, e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      st[i] = mk(5'd8, 5'd0, 0, 1, 1, 5'd8, 1, 1, 0);
      ex[i] = 6'b001000;
    end
    st[3] = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0); ex[3] = 6'b001000;
    for (int i = 0; i < 4; i++) begin
      apply(st[i], ex[i]);
      e = sb.pop_front();
      got = obs();
      n_vec++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL priority[%0d] got=%b exp=%b", i, got, e);
      end
    end
`ifdef HAZARD_PERF_CNT_EN
    n_vec++;
    if ({bus.stall_cnt, bus.flush_cnt} !== {32'd3, 32'd0}) begin
      n_bad++;
      $display("FAIL priority_cnt got=%0d/%0d exp=3/0", bus.stall_cnt, bus.flush_cnt);
    end
`endif
    // Asynchronous reset while still in MEM_WAIT, before the next rising edge.
    #1;
    rst_n = 1'b0;
    #1;
    got = obs();
    n_vec++;
    if (got !== 6'b110000) begin
      n_bad++;
      $display("FAIL async_reset got=%b exp=%b", got, 6'b110000);
    end
`ifdef HAZARD_PERF_CNT_EN
    n_vec++;
    if ({bus.stall_cnt, bus.flush_cnt} !== 64'd0) begin
      n_bad++;
      $display("FAIL async_reset_cnt got=%0d/%0d exp=0/0", bus.stall_cnt, bus.flush_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    st[4] = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0); ex[4] = 6'b110000;
    st[5] = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0); ex[5] = 6'b110000;
    for (int i = 4; i < 6; i++) begin
      apply(st[i], ex[i]);
      e = sb.pop_front();
      got = obs();
      n_vec++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL release[%0d] got=%b exp=%b", i, got, e);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0));
    test_reset();
    test_load_use();
    test_rt_gate();
    test_branch();
    test_back_to_back();
    test_mem_wait();
    test_timeout();
    test_priority_reset();
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
